aer_transmitter: RTL and testbench
==================================

Name: aer_transmitter

Overview:
- Sender side of the DVS four-phase AER handshake; the counterpart of the team's AER receiver.
- Accepts one pixel event (y, x, polarity) over a valid/ready interface and serialises it as two AER words: Y word first (xsel=0), then X word (xsel=1).
- Each word is a full REQ/ACK four-phase handshake, and AER data is held stable for a setup interval before REQ rises.
- Used as a DVS camera emulator for loopback tests and as the event source toward RAVENS-side links.

Parameters:
- SETUP_NS, 50: minimum time from AER data stable to REQ assertion.
- SETUP_CYCLES, max(1, ceil(SETUP_NS/CLK_PERIOD)): setup counter load value. CLK_PERIOD comes from dvs_ravens_pkg; default 10 gives 5.
- ACK_TIMEOUT_CYCLES, 1024: watchdog limit; used only with AER_TX_ACK_TIMEOUT_EN.

Ports:
- clk  in  1  single system clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- ev_valid  in  1  event offered.
- ev_ready  out  1  transmitter can accept an event.
- ev_y  in  10  row address.
- ev_x  in  9  column address.
- ev_pol  in  1  polarity.
- aer  out  10  AER bus.
- xsel  out  1  0 = Y word, 1 = X word.
- req  out  1  AER request.
- ack  in  1  AER acknowledge; asynchronous, synchronised internally.
- tx_done  out  1  one-cycle pulse when the X-word handshake completes.
- tx_err  out  1  one-cycle pulse on ACK timeout; tied 0 when the feature is off.

Behaviour:
- Reset: state IDLE; aer=0, xsel=0, req=0, tx_done=0, tx_err=0; ack sync flops cleared. ev_ready=1 from the first cycle after reset deasserts.
- ack passes through a 2-FF synchroniser to give ack_s. All decisions use ack_s.
- Outputs aer, xsel and req are registered. No combinational path from ack to any output.
- State IDLE:
  - ev_ready=1.
  - On ev_valid&&ev_ready: latch y, x and pol; drive aer=ev_y, xsel=0; load setup counter with SETUP_CYCLES; go to SETUP.
- State SETUP:
  - ev_ready=0; aer and xsel held.
  - Counter decrements each cycle, saturating at 0.
  - When counter==0 and ack_s==0: req<=1, go to WAIT_ACK_HI.
  - If ack_s is still high, which is a protocol violation, stay in SETUP with req low until ack_s==0.
- State WAIT_ACK_HI: hold req=1 and data until ack_s==1, then req<=0 and go to WAIT_ACK_LO.
- State WAIT_ACK_LO: wait for ack_s==0, then:
  - If xsel==0: drive aer={x,pol}, i.e. aer[9:1]=x and aer[0]=pol; xsel<=1; reload the counter; go to SETUP.
  - If xsel==1: tx_done<=1 for one cycle; go to IDLE.
- aer and xsel change only in IDLE or on the WAIT_ACK_LO exit. They never change while req=1 or while ack_s=1.
- Latency: with SETUP_CYCLES=N, req rises N+1 cycles after the accepting edge.
- Back-to-back events: ev_ready reasserts the cycle after tx_done.
- Unknown or illegal state encoding goes to IDLE with req=0.
- Reset mid-handshake: req drops at that edge, the in-flight event is discarded, and no tx_done is issued.

Optional Feature:
- Macro AER_TX_ACK_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles spent in WAIT_ACK_HI or WAIT_ACK_LO, cleared on each state entry.
  - On reaching ACK_TIMEOUT_CYCLES: req<=0, tx_err pulses once, event dropped, go to IDLE.
  - The next event still waits in SETUP for ack_s==0.
- Undefined: no watchdog logic; tx_err is constant 0; the transmitter waits indefinitely.

Decomposition:
- Add to dvs_ravens_pkg:
  - aer_tx_state_t enum {IDLE, SETUP, WAIT_ACK_HI, WAIT_ACK_LO}.
  - AER_SETUP_NS=50.
  - AER_WIDTH=10.
  - Existing CLK_PERIOD.
- One sub-module, sync_2ff: parameterised-width double-FF synchroniser with synchronous active-high reset, instantiated here for ack. It is reusable by the receiver.

Test Plan:
- Single event, SETUP_CYCLES=5, ev_y=0x123, ev_x=0x0A5, ev_pol=1, responder acks after 3 cycles:
  - Y word: aer=0x123, xsel=0, stable 5 cycles before req rises, req low after ack_s high.
  - X word: aer=0x14B, xsel=1.
  - Exactly one tx_done pulse.
- Two events offered back-to-back: ev_ready=0 from accept until the cycle after tx_done; the second event's Y word follows with no lost or merged words.
- ack held high at event accept: req stays low in SETUP until ack falls, then proceeds normally.
- rst asserted while req=1 in the X-word WAIT_ACK_HI: next cycle req=0, aer=0, xsel=0, no tx_done; next event transmits normally.
- With AER_TX_ACK_TIMEOUT_EN and ACK_TIMEOUT_CYCLES=16, ack never asserted: req drops and tx_err pulses exactly 16 cycles after WAIT_ACK_HI entry; ev_ready=1 the next cycle.
- Without the macro, same stimulus: req stays 1 indefinitely (checked for 2000 cycles); tx_err stays 0.

Source files
------------

// File: rtl/dvs_ravens_pkg.sv
// Shared DVS/RAVENS definitions: clock period, AER bus width and transmitter state encoding.
package dvs_ravens_pkg;

  localparam int unsigned CLK_PERIOD   = 10;
  localparam int unsigned AER_SETUP_NS = 50;
  localparam int unsigned AER_WIDTH    = 10;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT_ACK_HI,
    WAIT_ACK_LO
  } aer_tx_state_t;

  // Setup time in cycles, rounded up and never below one.
  function automatic int unsigned setup_cycles(input int unsigned setup_ns,
                                               input int unsigned clk_period);
    int unsigned c;
    c = (setup_ns + clk_period - 1) / clk_period;
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Double-flop synchroniser for asynchronous level inputs, synchronous active-high reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/aer_transmitter.sv
// Four-phase AER sender: one pixel event becomes a Y word then an X word, each with REQ/ACK.
// Optional ACK watchdog enabled by defining AER_TX_ACK_TIMEOUT_EN.
module aer_transmitter
  import dvs_ravens_pkg::*;
#(
  parameter int unsigned SETUP_NS           = AER_SETUP_NS,
  parameter int unsigned SETUP_CYCLES       = setup_cycles(SETUP_NS, CLK_PERIOD),
  parameter int unsigned ACK_TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ev_valid,
  output logic                 ev_ready,
  input  logic [9:0]           ev_y,
  input  logic [8:0]           ev_x,
  input  logic                 ev_pol,
  output logic [AER_WIDTH-1:0] aer,
  output logic                 xsel,
  output logic                 req,
  input  logic                 ack,
  output logic                 tx_done,
  output logic                 tx_err
);

  localparam int unsigned CntW = $clog2(SETUP_CYCLES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(SETUP_CYCLES);

  aer_tx_state_t        state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [AER_WIDTH-1:0] aer_q, aer_d;
  logic                 xsel_q, xsel_d;
  logic                 req_q, req_d;
  logic [8:0]           x_q, x_d;
  logic                 pol_q, pol_d;
  logic                 tx_done_q, tx_done_d;
  logic                 ack_s;

  sync_2ff #(
    .WIDTH(1)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d_i (ack),
    .q_o (ack_s)
  );

`ifdef AER_TX_ACK_TIMEOUT_EN
  localparam int unsigned WdW = (ACK_TIMEOUT_CYCLES < 2) ? 1 : $clog2(ACK_TIMEOUT_CYCLES);
  localparam logic [WdW-1:0] WdLast = WdW'(ACK_TIMEOUT_CYCLES - 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           tx_err_q, tx_err_d;

  // Hold off new events during the pulse cycle so a new accept never overlaps a report.
  assign ev_ready = (state_q == IDLE) && !tx_done_q && !tx_err_q;
  assign tx_err   = tx_err_q;
`else
  assign ev_ready = (state_q == IDLE) && !tx_done_q;
  assign tx_err   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    aer_d     = aer_q;
    xsel_d    = xsel_q;
    req_d     = req_q;
    x_d       = x_q;
    pol_d     = pol_q;
    tx_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        req_d = 1'b0;
        if (ev_valid && ev_ready) begin
          x_d     = ev_x;
          pol_d   = ev_pol;
          aer_d   = ev_y;
          xsel_d  = 1'b0;
          cnt_d   = CntLoad;
          state_d = SETUP;
        end
      end
      SETUP: begin
        req_d = 1'b0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!ack_s) begin
          req_d   = 1'b1;
          state_d = WAIT_ACK_HI;
        end
      end
      WAIT_ACK_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = WAIT_ACK_LO;
        end
      end
      WAIT_ACK_LO: begin
        if (!ack_s) begin
          if (!xsel_q) begin
            aer_d   = {x_q, pol_q};
            xsel_d  = 1'b1;
            cnt_d   = CntLoad;
            state_d = SETUP;
          end else begin
            tx_done_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

`ifdef AER_TX_ACK_TIMEOUT_EN
    tx_err_d = 1'b0;
    wd_d     = '0;
    if ((state_q == WAIT_ACK_HI) || (state_q == WAIT_ACK_LO)) begin
      if (wd_q == WdLast) begin
        req_d     = 1'b0;
        tx_err_d  = 1'b1;
        tx_done_d = 1'b0;
        state_d   = IDLE;
      end else if (state_d == state_q) begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      aer_q     <= '0;
      xsel_q    <= 1'b0;
      req_q     <= 1'b0;
      x_q       <= '0;
      pol_q     <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      aer_q     <= aer_d;
      xsel_q    <= xsel_d;
      req_q     <= req_d;
      x_q       <= x_d;
      pol_q     <= pol_d;
      tx_done_q <= tx_done_d;
    end
  end

`ifdef AER_TX_ACK_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q     <= '0;
      tx_err_q <= 1'b0;
    end else begin
      wd_q     <= wd_d;
      tx_err_q <= tx_err_d;
    end
  end
`endif

  assign aer     = aer_q;
  assign xsel    = xsel_q;
  assign req     = req_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_aer_transmitter.sv
// Bench for aer_transmitter: protocol-level model checked every cycle plus directed scenarios.
module tb_aer_transmitter;

  localparam int unsigned N = 5;  // 50 ns setup at 10 ns clock

  logic       clk = 1'b0;
  logic       rst;
  logic       ev_valid;
  logic       ev_ready;
  logic [9:0] ev_y;
  logic [8:0] ev_x;
  logic       ev_pol;
  logic [9:0] aer;
  logic       xsel;
  logic       req;
  logic       ack;
  logic       tx_done;
  logic       tx_err;

  aer_transmitter #(
    .ACK_TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_y     (ev_y),
    .ev_x     (ev_x),
    .ev_pol   (ev_pol),
    .aer      (aer),
    .xsel     (xsel),
    .req      (req),
    .ack      (ack),
    .tx_done  (tx_done),
    .tx_err   (tx_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Responder: follows req with ack after 3 cycles, or drives a forced level.
  logic resp_en   = 1'b0;
  logic force_val = 1'b0;
  initial begin
    int rcnt;
    rcnt = 0;
    ack  = 1'b0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        ack  = force_val;
        rcnt = 0;
      end else if (req !== ack) begin
        rcnt++;
        if (rcnt >= 3) begin
          ack  = req;
          rcnt = 0;
        end
      end else begin
        rcnt = 0;
      end
    end
  end

  // Model state
  logic [10:0] exp_q[$];   // {xsel, aer} words still to be sent
  logic [10:0] log_q[$];   // words seen at each req rise
  int          done_cnt = 0;
  int          err_cnt  = 0;

  initial begin
    logic       started, exp_ready, pending, accepted, changed, exact_ok, done_exp;
    logic       p_req, p_xsel, p_ready, p_done, p_err;
    logic [9:0] p_aer;
    logic [2:0] hist;
    logic [10:0] w;
    int         stable;
    started = 0; exp_ready = 1; pending = 0; exact_ok = 0; stable = 0; hist = '0;
    p_req = 0; p_xsel = 0; p_ready = 0; p_done = 0; p_err = 0; p_aer = '0;
    forever begin
      @(posedge clk);
      #1;
      hist = {hist[1:0], ack};
      if (rst) begin
        check("rst_req", req, 0);
        check("rst_aer", aer, 0);
        check("rst_xsel", xsel, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_tx_err", tx_err, 0);
        exp_q.delete();
        pending   = 0;
        exp_ready = 1;
        stable    = 0;
        exact_ok  = 0;
        started   = 1;
      end else if (started) begin
        accepted = p_ready && ev_valid;
        if (accepted) exp_ready = 0;
        else if (p_done || p_err) exp_ready = 1;
        check("ev_ready", ev_ready, exp_ready);
        if (accepted) begin
          exp_q.push_back({1'b0, ev_y});
          exp_q.push_back({1'b1, ev_x, ev_pol});
        end

        changed = (aer !== p_aer) || (xsel !== p_xsel);
        if (changed) begin
          check("chg_while_req", p_req, 0);
          check("chg_cause", accepted || (xsel && !p_xsel), 1);
          if (xsel && !p_xsel) check("chg_while_ack_s", hist[2], 0);
          stable   = 0;
          exact_ok = (hist == 3'b000);
        end else begin
          stable++;
          if (ack) exact_ok = 0;
        end

        done_exp = pending && !hist[2];
        check("tx_done", tx_done, done_exp);
        if (tx_done) begin
          pending = 0;
          done_cnt++;
        end

        if (req && !p_req) begin
          check("rise_ack_s_low", hist[2], 0);
          if (exact_ok) check("rise_latency", stable, N + 1);
          else check("rise_min_setup", (stable >= N + 1), 1);
          if (exp_q.size() == 0) begin
            check("rise_unexpected", 1, 0);
          end else begin
            w = exp_q.pop_front();
            check("word_aer", aer, w[9:0]);
            check("word_xsel", xsel, w[10]);
          end
          log_q.push_back({xsel, aer});
        end
        if (p_req && hist[2]) check("req_drop_on_ack_s", req, 0);
        if (!req && p_req) begin
          if (!tx_err) check("fall_on_ack_s", hist[2], 1);
          if (xsel && !tx_err) pending = 1;
        end

`ifdef AER_TX_ACK_TIMEOUT_EN
        if (tx_err) begin
          check("err_req_low", req, 0);
          err_cnt++;
          exp_q.delete();
          pending = 0;
        end
`else
        check("tx_err_zero", tx_err, 0);
`endif
      end
      p_req = req; p_xsel = xsel; p_aer = aer;
      p_ready = ev_ready; p_done = tx_done; p_err = tx_err;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with ev_valid still high.
  task automatic send_event(input logic [9:0] y, input logic [8:0] x, input logic pol);
    int k;
    ev_y = y; ev_x = x; ev_pol = pol; ev_valid = 1'b1;
    k = 0;
    while (!ev_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!ev_ready) check("accept_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_cnt < target && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("wait_done", (done_cnt >= target), 1);
  endtask

  task automatic wait_req(input logic xs);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(req && xsel == xs) && k < 500);
    check("wait_req", req && (xsel == xs), 1);
  endtask

  initial begin
    int base, d0, hi, k;
    rst = 1'b1; ev_valid = 1'b0; ev_y = '0; ev_x = '0; ev_pol = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", ev_ready, 1);

    // Single event
    resp_en = 1'b1;
    base = log_q.size(); d0 = done_cnt;
    send_event(10'h123, 9'h0A5, 1'b1);
    ev_valid = 1'b0;
    wait_done(d0 + 1);
    repeat (5) @(negedge clk);
    check("t1_words", log_q.size() - base, 2);
    check("t1_y", log_q[base], {1'b0, 10'h123});
    check("t1_x", log_q[base+1], {1'b1, 10'h14B});
    check("t1_done", done_cnt - d0, 1);

    // Back-to-back events
    base = log_q.size(); d0 = done_cnt;
    send_event(10'h3FF, 9'h1FF, 1'b0);
    send_event(10'h001, 9'h000, 1'b1);
    ev_valid = 1'b0;
    wait_done(d0 + 2);
    repeat (5) @(negedge clk);
    check("t2_words", log_q.size() - base, 4);
    check("t2_y0", log_q[base], {1'b0, 10'h3FF});
    check("t2_x0", log_q[base+1], {1'b1, 10'h3FE});
    check("t2_y1", log_q[base+2], {1'b0, 10'h001});
    check("t2_x1", log_q[base+3], {1'b1, 10'h001});

    // ack held high at accept
    resp_en = 1'b0; force_val = 1'b1;
    repeat (4) @(negedge clk);
    base = log_q.size(); d0 = done_cnt; hi = 0;
    send_event(10'h2AA, 9'h155, 1'b0);
    ev_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (req) hi++;
    end
    check("t3_req_held_low", hi, 0);
    force_val = 1'b0;
    @(negedge clk);
    resp_en = 1'b1;
    wait_done(d0 + 1);
    repeat (5) @(negedge clk);
    check("t3_y", log_q[base], {1'b0, 10'h2AA});
    check("t3_x", log_q[base+1], {1'b1, 10'h2AA});

    // Reset during X-word WAIT_ACK_HI
    d0 = done_cnt;
    send_event(10'h0F0, 9'h00F, 1'b1);
    ev_valid = 1'b0;
    wait_req(1'b1);
    resp_en = 1'b0; force_val = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_req", req, 0);
    check("t4_aer", aer, 0);
    check("t4_xsel", xsel, 0);
    repeat (10) @(negedge clk);
    check("t4_no_done", done_cnt - d0, 0);
    resp_en = 1'b1;
    base = log_q.size(); d0 = done_cnt;
    send_event(10'h155, 9'h0AA, 1'b0);
    ev_valid = 1'b0;
    wait_done(d0 + 1);
    repeat (5) @(negedge clk);
    check("t4_y", log_q[base], {1'b0, 10'h155});
    check("t4_x", log_q[base+1], {1'b1, 10'h154});

    // ack never answers
    resp_en = 1'b0; force_val = 1'b0;
    send_event(10'h200, 9'h100, 1'b1);
    ev_valid = 1'b0;
    wait_req(1'b0);
`ifdef AER_TX_ACK_TIMEOUT_EN
    k = 0;
    while (!tx_err && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("t5_timeout_cycles", k, 16);
    check("t5_req_dropped", req, 0);
    @(negedge clk);
    check("t5_ready_after_err", ev_ready, 1);
    check("t5_err_count", err_cnt, 1);
`else
    hi = 0; k = 0;
    repeat (2000) begin
      @(negedge clk);
      if (!req) hi++;
      if (tx_err) k++;
    end
    check("t5_req_held", hi, 0);
    check("t5_no_err", k, 0);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
